// File: rtl/dma_pkg.sv
// dma_pkg: shared parameters, state encoding and the block-count clamp for
// the DMA block controller.
//   WORD_SIZE   - width of one memory word and of an address
//   BLOCK_WORDS - words per device block (device data = BLOCK_WORDS*WORD_SIZE)
//   NUM_BLOCKS  - blocks held by the device (offsets 0..NUM_BLOCKS-1)
//   OFFSET_BITS - device offset width (must also hold the value NUM_BLOCKS)
package dma_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int BLOCK_WORDS = 4;
  localparam int NUM_BLOCKS  = 3;
  localparam int OFFSET_BITS = 2;
  localparam int DATA_W      = BLOCK_WORDS * WORD_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_NEXT = 3'd3,
    ST_REL  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Whole blocks in a word length, clamped to what the device holds.
  // The two low bits (a partial block) are dropped.
  function automatic logic [OFFSET_BITS-1:0] clamp_count(
    input logic [WORD_SIZE-1:0] len
  );
    logic [WORD_SIZE-1:0] blocks;
    blocks = len >> 2;
    if (blocks > WORD_SIZE'(NUM_BLOCKS)) begin
      return OFFSET_BITS'(NUM_BLOCKS);
    end
    return blocks[OFFSET_BITS-1:0];
  endfunction

endpackage

// File: rtl/dma_block_counter.sv
// dma_block_counter: device offset / destination address counter.
//   clk, reset_n - clock, asynchronous active-low reset
//   i_load       - start of a command: clear offset, latch base and count
//   i_base       - destination base address
//   i_count      - number of blocks in this command
//   i_step       - one block written: advance the offset
//   o_offset     - current device offset
//   o_addr       - base + 4*offset (wraps modulo 2^WORD_SIZE)
//   o_last       - offset has reached the block count
module dma_block_counter
  import dma_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_load,
  input  logic [WORD_SIZE-1:0]   i_base,
  input  logic [OFFSET_BITS-1:0] i_count,
  input  logic                   i_step,
  output logic [OFFSET_BITS-1:0] o_offset,
  output logic [WORD_SIZE-1:0]   o_addr,
  output logic                   o_last
);

  logic [OFFSET_BITS-1:0] r_offset;
  logic [OFFSET_BITS-1:0] r_count;
  logic [WORD_SIZE-1:0]   r_base;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_offset <= '0;
      r_count  <= '0;
      r_base   <= '0;
    end else if (i_load) begin
      r_offset <= '0;
      r_count  <= i_count;
      r_base   <= i_base;
    end else if (i_step) begin
      r_offset <= r_offset + 1'b1;
    end
  end

  // Each block is BLOCK_WORDS (4) words, hence the shift by two.
  assign o_addr   = r_base + (WORD_SIZE'(r_offset) << 2);
  assign o_offset = r_offset;
  assign o_last   = (r_offset == r_count);

endmodule

// File: rtl/dma_block_controller.sv
// dma_block_controller: copies whole device blocks into main memory on a
// CPU start command, borrowing the memory bus through BR/BG.
//   clk, reset_n          - clock, asynchronous active-low reset
//   cmd_start/addr/length - CPU start pulse, destination base, word length
//   busy                  - command in progress (start .. dma_end inclusive)
//   br / bg               - bus request to CPU / bus grant from CPU
//   dev_offset / dev_data - device block select / block returned
//   mem_write / mem_addr / mem_wdata / mem_ack - block write port
//   dma_end               - one-cycle completion interrupt
//
// Handshakes: a block write is offered by holding mem_write with mem_addr,
// mem_wdata and dev_offset stable; it completes in the cycle mem_ack is
// sampled high while mem_write is high (mem_ack at any other time is ignored).
// The bus is owned only while br and bg are both high; br stays high for the
// whole of a write, and a bg drop is only acted on between blocks.
module dma_block_controller
  import dma_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_start,
  input  logic [WORD_SIZE-1:0]   cmd_addr,
  input  logic [WORD_SIZE-1:0]   cmd_length,
  output logic                   busy,
  output logic                   br,
  input  logic                   bg,
  output logic [OFFSET_BITS-1:0] dev_offset,
  input  logic [DATA_W-1:0]      dev_data,
  output logic                   mem_write,
  output logic [WORD_SIZE-1:0]   mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  output logic                   dma_end
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_busy;
  logic                   r_dma_end;
  logic [DATA_W-1:0]      r_wdata;

  logic                   w_accept;
  logic [OFFSET_BITS-1:0] w_count;
  logic                   w_step;
  logic                   w_last;
  logic                   w_enter_xfer;
  logic [OFFSET_BITS-1:0] w_offset;
  logic [WORD_SIZE-1:0]   w_addr;

  // r_busy also covers the dma_end cycle (state already back in IDLE), so a
  // start is accepted only once both have settled.
  assign w_accept     = cmd_start && (r_state == ST_IDLE) && !r_busy;
  assign w_count      = clamp_count(cmd_length);
  assign w_step       = (r_state == ST_XFER) && mem_ack;
  assign w_enter_xfer = (w_next == ST_XFER) && (r_state != ST_XFER);

  dma_block_counter u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_accept),
    .i_base   (cmd_addr),
    .i_count  (w_count),
    .i_step   (w_step),
    .o_offset (w_offset),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (w_count == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bg) begin
          w_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (mem_ack) begin
          w_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // Offset was already advanced by the ack, so w_last means all done.
        if (w_last) begin
          w_next = ST_REL;
        end else if (bg) begin
          w_next = ST_XFER;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_REL: begin
        if (!bg) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    br        = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      ST_REQ:  br = 1'b1;
      ST_XFER: begin
        br        = 1'b1;
        mem_write = 1'b1;
      end
      ST_NEXT: br = 1'b1;
      default: begin
        br        = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Registered status: dma_end follows DONE by one cycle, busy clears after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= 1'b0;
      r_dma_end <= 1'b0;
    end else begin
      r_dma_end <= (r_state == ST_DONE);
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_dma_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Block data is snapped on entry to XFER so it cannot move mid-write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdata <= '0;
    end else if (w_enter_xfer) begin
      r_wdata <= dev_data;
    end
  end

  assign busy       = r_busy;
  assign dma_end    = r_dma_end;
  assign dev_offset = w_offset;
  assign mem_addr   = w_addr;
  assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_dma_block_controller.sv
// Bench for dma_block_controller: CPU, device and memory models around the
// DUT; expected block writes are queued at command issue and popped by an
// independent monitor on every completed write.
module tb_dma_block_controller;
  import dma_pkg::*;

  localparam int EW = OFFSET_BITS + WORD_SIZE + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   cmd_start = 1'b0;
  logic [WORD_SIZE-1:0]   cmd_addr = '0;
  logic [WORD_SIZE-1:0]   cmd_length = '0;
  logic                   busy;
  logic                   br;
  logic                   bg = 1'b0;
  logic [OFFSET_BITS-1:0] dev_offset;
  logic [DATA_W-1:0]      dev_data;
  logic                   mem_write;
  logic [WORD_SIZE-1:0]   mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_ack = 1'b0;
  logic                   dma_end;

  always #5 clk = ~clk;

  dma_block_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_start  (cmd_start),
    .cmd_addr   (cmd_addr),
    .cmd_length (cmd_length),
    .busy       (busy),
    .br         (br),
    .bg         (bg),
    .dev_offset (dev_offset),
    .dev_data   (dev_data),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .dma_end    (dma_end)
  );

  // Device: fixed block contents per command, selected by dev_offset.
  logic [DATA_W-1:0] dev_mem [4];
  assign dev_data = dev_mem[dev_offset];

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail = 0;
  logic [EW-1:0] exp_q[$];
  int            pending_end = 0;

  // Environment knobs
  bit bg_auto = 1'b1;
  bit preempt_en = 1'b0;
  int gnt_delay = 2;
  int ack_delay = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return br;
      1: return mem_write;
      2: return !mem_write;
      3: return !br;
      4: return !busy;
      5: return mem_write && (dev_offset == 2'd1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int t;
    t = 0;
    while (!cond(which) && t < 500) begin
      tick;
      t++;
    end
    if (!cond(which)) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s: condition %0d not reached in 500 cycles", name, which);
    end
  endtask

  // Reference model: blocks = min(len/4, NUM_BLOCKS); block i goes to
  // addr + 4*i (16-bit wrap) carrying device block i.
  task automatic issue(input logic [WORD_SIZE-1:0] len, input logic [WORD_SIZE-1:0] addr);
    int n;
    for (int i = 0; i < 4; i++) dev_mem[i] = {$urandom, $urandom};
    n = int'(len) / 4;
    if (n > NUM_BLOCKS) n = NUM_BLOCKS;
    for (int i = 0; i < n; i++) begin
      logic [WORD_SIZE-1:0] a;
      a = addr + WORD_SIZE'(4 * i);
      exp_q.push_back({OFFSET_BITS'(i), a, dev_mem[i]});
    end
    pending_end++;
    cmd_addr   = addr;
    cmd_length = len;
    cmd_start  = 1'b1;
    tick;
    cmd_start  = 1'b0;
  endtask

  // ---------------- CPU bus-grant model ----------------
  initial begin
    forever begin
      tick;
      if (bg_auto) begin
        if (br && !bg) begin
          repeat (gnt_delay) tick;
          if (br) bg = 1'b1;
        end else if (!br && bg) begin
          bg = 1'b0;
        end else if (bg && mem_write && preempt_en && ($urandom_range(0, 3) == 0)) begin
          bg = 1'b0;
        end
      end
    end
  end

  // ---------------- memory model ----------------
  initial begin
    int d;
    forever begin
      tick;
      if (mem_write) begin
        d = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
        repeat (d) tick;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0]          e;
    logic [DATA_W-1:0]      prev_wdata;
    logic [OFFSET_BITS-1:0] prev_off;
    bit                     prev_wr;
    prev_wr = 1'b0;
    prev_wdata = '0;
    prev_off = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_wr = 1'b0;
      end else begin
        if (mem_write) begin
          check("br_during_write", 64'(br), 64'd1);
          check("no_end_during_write", 64'(dma_end), 64'd0);
          if (prev_wr) begin
            check("wdata_stable", mem_wdata, prev_wdata);
            check("offset_stable", 64'(dev_offset), 64'(prev_off));
          end
          if (mem_ack) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_write: got addr 0x%0h offset %0d, expected no write",
                       mem_addr, dev_offset);
            end else begin
              e = exp_q.pop_front();
              check("write_offset", 64'(dev_offset), 64'(e[EW-1 -: OFFSET_BITS]));
              check("write_addr", 64'(mem_addr), 64'(e[DATA_W +: WORD_SIZE]));
              check("write_data", mem_wdata, e[DATA_W-1:0]);
            end
          end
        end
        if (dma_end) begin
          check("br_low_at_end", 64'(br), 64'd0);
          n_checks++;
          if (pending_end == 0) begin
            n_fail++;
            $display("FAIL unexpected_dma_end: got pulse, expected none");
          end else begin
            pending_end--;
          end
        end
        prev_wr    = mem_write && !mem_ack;
        prev_wdata = mem_wdata;
        prev_off   = dev_offset;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int busy_cyc;
    int br_seen;
    logic [WORD_SIZE-1:0] len;

    for (int i = 0; i < 4; i++) dev_mem[i] = '0;

    // Reset state
    #12;
    check("rst_br", 64'(br), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dma_end", 64'(dma_end), 64'd0);
    check("rst_dev_offset", 64'(dev_offset), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    reset_n = 1'b1;
    tick;

    // Length 12 at 0x0017, grant two cycles after br
    gnt_delay = 2;
    issue(16'd12, 16'h0017);
    check("br_one_cycle_after_start", 64'(br), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_for(4, "len12_done");
    check("len12_all_written", 64'(exp_q.size()), 64'd0);
    check("len12_end_seen", 64'(pending_end), 64'd0);

    // Length 0: no bus activity, busy for two cycles, one dma_end
    tick;
    issue(16'd0, 16'h1234);
    busy_cyc = 0;
    br_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_cyc++;
      if (br) br_seen++;
      tick;
    end
    check("len0_busy_cycles", 64'(busy_cyc), 64'd2);
    check("len0_br_never", 64'(br_seen), 64'd0);
    check("len0_end_seen", 64'(pending_end), 64'd0);

    // Clamp to three blocks, and a partial-block length
    gnt_delay = 0;
    issue(16'd40, 16'h0100);
    wait_for(4, "len40_done");
    check("len40_all_written", 64'(exp_q.size()), 64'd0);
    issue(16'd6, 16'h0200);
    wait_for(4, "len6_done");
    check("len6_all_written", 64'(exp_q.size()), 64'd0);

    // Grant withdrawn during block 1; write finishes, controller re-requests
    bg_auto = 1'b0;
    ack_delay = 3;
    tick;
    issue(16'd12, 16'h0400);
    wait_for(0, "pre_br");
    tick;
    bg = 1'b1;
    tick;
    check("grant_to_write_latency", 64'(mem_write), 64'd1);
    wait_for(5, "pre_block1");
    bg = 1'b0;
    wait_for(2, "pre_block1_done");
    tick;
    check("pre_rerequest_br", 64'(br), 64'd1);
    check("pre_no_write_without_bg", 64'(mem_write), 64'd0);
    check("pre_resume_offset", 64'(dev_offset), 64'd2);
    tick;
    tick;
    check("pre_still_waiting", 64'(mem_write), 64'd0);
    bg = 1'b1;
    tick;
    check("pre_block2_write", 64'(mem_write), 64'd1);
    check("pre_block2_addr", 64'(mem_addr), 64'h0408);
    wait_for(3, "pre_release");
    bg = 1'b0;
    wait_for(4, "pre_done");
    check("pre_all_written", 64'(exp_q.size()), 64'd0);

    // Start pulsed mid-transfer with another address is ignored
    bg_auto = 1'b1;
    ack_delay = 2;
    gnt_delay = 1;
    tick;
    issue(16'd12, 16'h0800);
    wait_for(1, "ign_xfer");
    cmd_addr = 16'h5555;
    cmd_length = 16'd4;
    cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    wait_for(4, "ign_done");
    check("ign_all_written", 64'(exp_q.size()), 64'd0);
    check("ign_single_end", 64'(pending_end), 64'd0);

    // Asynchronous reset in the middle of a write
    tick;
    issue(16'd12, 16'h0C00);
    wait_for(1, "rst_xfer");
    #2;
    reset_n = 1'b0;
    #1;
    check("amid_br", 64'(br), 64'd0);
    check("amid_mem_write", 64'(mem_write), 64'd0);
    check("amid_busy", 64'(busy), 64'd0);
    check("amid_mem_addr", 64'(mem_addr), 64'd0);
    exp_q.delete();
    pending_end = 0;
    tick;
    #3;
    reset_n = 1'b1;
    tick;
    tick;
    issue(16'd8, 16'h0040);
    wait_for(4, "post_rst_done");
    check("post_rst_all_written", 64'(exp_q.size()), 64'd0);

    // Randomised commands with random grant, ack latency and preemption
    preempt_en = 1'b1;
    ack_delay = -1;
    for (int k = 0; k < 25; k++) begin
      wait_for(4, "rand_idle");
      repeat ($urandom_range(0, 3)) tick;
      gnt_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) len = WORD_SIZE'($urandom_range(0, 65535));
      else len = WORD_SIZE'($urandom_range(0, 16));
      if (k == 0) issue(16'd12, 16'hFFFC);
      else issue(len, WORD_SIZE'($urandom_range(0, 65535)));
    end
    wait_for(4, "rand_final");
    tick;
    tick;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_no_pending_end", 64'(pending_end), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
